// File: rtl/i2c_master_txn_seq.sv
// Transaction sequencer for an I2C byte controller: turns one host request into
// START, address WRITE, N data WRITE/READ commands and STOP, with NACK/arbitration/abort handling.
module i2c_master_txn_seq (
  input  logic       sysclk_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic       start_i,
  input  logic [6:0] slave_addr_i,
  input  logic       rw_i,
  input  logic [7:0] len_i,
  input  logic       abort_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_valid_i,
  output logic       tx_ready_o,
  output logic [7:0] rx_data_o,
  output logic       rx_valid_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       nack_o,
  output logic       al_o,
  output logic [2:0] byte_cmd_o,
  output logic [7:0] byte_data_o,
  output logic       master_ack_o,
  input  logic       byte_cmd_ack_i,
  input  logic       byte_ack_i,
  input  logic       byte_al_i,
  input  logic [7:0] byte_data_i
);

  localparam logic [2:0] CMD_NOP   = 3'd0;
  localparam logic [2:0] CMD_START = 3'd1;
  localparam logic [2:0] CMD_STOP  = 3'd2;
  localparam logic [2:0] CMD_WRITE = 3'd3;
  localparam logic [2:0] CMD_READ  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_WFETCH, S_WDATA, S_RDATA, S_STOP, S_DONE
  } state_t;

  // Handshake: a command on byte_cmd_o is held stable until the cycle byte_cmd_ack_i=1;
  // the next command appears the cycle after. tx moves a byte when tx_valid_i & tx_ready_o.
  state_t     state_q, state_d;
  logic [6:0] addr_q;
  logic       rw_q;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] cmd_q, cmd_d;
  logic [7:0] data_q, data_d;
  logic       mack_q, mack_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       nack_q, nack_d;
  logic       al_q, al_d;
  logic       capture;
  logic       tx_take;
  logic       al_hit;

  assign al_hit  = byte_al_i && (state_q != S_IDLE) && (state_q != S_DONE);
  assign tx_take = (state_q == S_WFETCH) && enable_i && !al_hit && !abort_i && tx_valid_i;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    nack_d     = nack_q;
    al_d       = al_q;
    capture    = 1'b0;
    if (!enable_i) begin
      state_d   = S_IDLE;
      rx_data_d = 8'h00;
    end else if (al_hit) begin
      // Arbitration loss wins over everything; any byte acked this cycle is dropped.
      al_d    = 1'b1;
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            capture = 1'b1;
            cnt_d   = len_i;
            nack_d  = 1'b0;
            al_d    = 1'b0;
            state_d = S_START;
          end
        end
        S_START: begin
          if (byte_cmd_ack_i) state_d = abort_i ? S_STOP : S_ADDR;
        end
        S_ADDR: begin
          if (byte_cmd_ack_i) begin
            if (byte_ack_i) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else if (abort_i || (cnt_q == 8'd0)) begin
              state_d = S_STOP;
            end else begin
              state_d = rw_q ? S_RDATA : S_WFETCH;
            end
          end
        end
        S_WFETCH: begin
          if (abort_i)      state_d = S_STOP;
          else if (tx_take) state_d = S_WDATA;
        end
        S_WDATA: begin
          if (byte_cmd_ack_i) begin
            cnt_d = cnt_q - 8'd1;
            if (byte_ack_i) begin
              nack_d  = 1'b1;
              state_d = S_STOP;
            end else if (abort_i || (cnt_d == 8'd0)) begin
              state_d = S_STOP;
            end else begin
              state_d = S_WFETCH;
            end
          end
        end
        S_RDATA: begin
          if (byte_cmd_ack_i) begin
            rx_data_d  = byte_data_i;
            rx_valid_d = 1'b1;
            cnt_d      = cnt_q - 8'd1;
            if (abort_i || (cnt_d == 8'd0)) state_d = S_STOP;
          end
        end
        S_STOP: begin
          if (byte_cmd_ack_i) state_d = S_DONE;
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end

    // Command registers are loaded from the state being entered.
    cmd_d  = CMD_NOP;
    data_d = 8'hff;
    mack_d = 1'b1;
    case (state_d)
      S_START: cmd_d = CMD_START;
      S_ADDR: begin
        cmd_d  = CMD_WRITE;
        data_d = {addr_q, rw_q};
      end
      S_WDATA: begin
        cmd_d  = CMD_WRITE;
        data_d = (state_q == S_WFETCH) ? tx_data_i : data_q;
      end
      S_RDATA: begin
        cmd_d  = CMD_READ;
        mack_d = (cnt_d == 8'd1);
      end
      S_STOP: cmd_d = CMD_STOP;
      default: cmd_d = CMD_NOP;
    endcase
  end

  always_ff @(posedge sysclk_i) begin
    if (reset_i) begin
      state_q    <= S_IDLE;
      addr_q     <= 7'h00;
      rw_q       <= 1'b0;
      cnt_q      <= 8'h00;
      cmd_q      <= CMD_NOP;
      data_q     <= 8'hff;
      mack_q     <= 1'b1;
      rx_data_q  <= 8'h00;
      rx_valid_q <= 1'b0;
      nack_q     <= 1'b0;
      al_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cmd_q      <= cmd_d;
      data_q     <= data_d;
      mack_q     <= mack_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      nack_q     <= nack_d;
      al_q       <= al_d;
      if (capture) begin
        addr_q <= slave_addr_i;
        rw_q   <= rw_i;
      end
    end
  end

  assign byte_cmd_o   = al_hit ? CMD_NOP : cmd_q;
  assign byte_data_o  = data_q;
  assign master_ack_o = mack_q;
  assign tx_ready_o   = tx_take;
  assign rx_data_o    = rx_data_q;
  assign rx_valid_o   = rx_valid_q;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_DONE);
  assign nack_o       = nack_q;
  assign al_o         = al_q;

endmodule

// File: doc/i2c_master_txn_seq.md
Name: i2c_master_txn_seq

Overview:
Transaction-level sequencer that drives one i2c_master_byte_ctl instance. It turns a single host request (7-bit slave address, direction, byte count) into the byte-controller command sequence START, address WRITE, data WRITE/READ ×N, STOP. It handles slave ACK/NACK, arbitration loss and host abort, and moves payload through valid/ready-style TX and RX streams. It sits between the register/host interface and the byte controller.

Parameters:
CMD_NOP, 3'd0, byte-controller idle command
CMD_START, 3'd1, generate START / repeated START
CMD_STOP, 3'd2, generate STOP
CMD_WRITE, 3'd3, shift out one byte, sample slave ACK
CMD_READ, 3'd4, shift in one byte, drive master ACK bit

Ports:
sysclk_i  in  1  system clock
reset_i  in  1  synchronous reset, active-high
enable_i  in  1  core enable; low forces IDLE (no STOP issued)
start_i  in  1  one-cycle request; sampled only in IDLE
slave_addr_i  in  7  target address, captured on accepted start_i
rw_i  in  1  1=read, 0=write, captured with start_i
len_i  in  8  payload byte count, captured; 0 = address-only probe
abort_i  in  1  host abort; level, sampled every cycle
tx_data_i  in  8  write payload byte
tx_valid_i  in  1  tx_data_i valid
tx_ready_o  out  1  byte consumed this cycle
rx_data_o  out  8  received byte
rx_valid_o  out  1  one-cycle strobe, rx_data_o valid
busy_o  out  1  transaction in progress (state != IDLE)
done_o  out  1  one-cycle strobe at transaction end
nack_o  out  1  status: slave NACKed (valid at done_o, held until next start)
al_o  out  1  status: arbitration lost (same hold rule)
byte_cmd_o  out  3  command to byte controller
byte_data_o  out  8  byte to transmit
master_ack_o  out  1  ACK bit to drive after READ (0=ACK, 1=NACK)
byte_cmd_ack_i  in  1  byte controller command-complete pulse
byte_ack_i  in  1  slave ACK bit sampled on WRITE (0=ACK), valid with byte_cmd_ack_i
byte_al_i  in  1  arbitration lost
byte_data_i  in  8  read byte, valid with byte_cmd_ack_i

Behaviour:
- Reset: state IDLE; byte_cmd_o=CMD_NOP, byte_data_o=8'hff, master_ack_o=1, tx_ready_o=0, rx_data_o=0, rx_valid_o=0, busy_o=0, done_o=0, nack_o=0, al_o=0; remaining-count register 0.
- Command handshake: byte_cmd_o (and byte_data_o / master_ack_o) is registered and held stable until the cycle byte_cmd_ack_i=1. The next command is presented on the following cycle. Exactly one command is issued per ack.
- IDLE: start_i & enable_i captures addr/rw/len, clears nack_o/al_o, goes to START. Otherwise byte_cmd_o=NOP.
- START: issue CMD_START. On ack go to ADDR.
- ADDR: issue CMD_WRITE with byte_data_o={addr,rw}. On ack:
  - byte_ack_i=1 → set nack_o, go to STOP.
  - byte_ack_i=0 and len=0 → STOP.
  - byte_ack_i=0, rw=0 → WFETCH.
  - byte_ack_i=0, rw=1 → RDATA.
- WFETCH: byte_cmd_o=NOP, tx_ready_o=tx_valid_i. On handshake, latch the byte and go to WDATA. Waits indefinitely; the bus is held by the byte controller.
- WDATA: issue CMD_WRITE. On ack, decrement the count.
  - byte_ack_i=1 → set nack_o, go to STOP, even if bytes remain.
  - Else if count reaches 0 → STOP.
  - Else → WFETCH.
- RDATA: issue CMD_READ with master_ack_o=1 when this is the final byte (count==1), otherwise 0. On ack: rx_data_o=byte_data_i, rx_valid_o=1 for one cycle, decrement the count; count reaches 0 → STOP, else stay in RDATA. RX has no backpressure.
- STOP: issue CMD_STOP. On ack go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Arbitration loss: byte_al_i=1 in any non-IDLE state takes priority over all other events.
  - Same cycle: set al_o, byte_cmd_o=NOP.
  - Next state is DONE, with no STOP issued.
  - An rx byte acked in that same cycle is discarded.
- abort_i=1 in START/ADDR/WFETCH/WDATA/RDATA:
  - The in-flight command is allowed to complete (wait for its ack).
  - Then go to STOP; nack_o is not set.
  - In WFETCH (no command in flight) go to STOP immediately.
  - Lower priority than byte_al_i.
- enable_i=0 in any state: next state IDLE, outputs return to reset values except nack_o/al_o; no done_o.
- start_i while busy_o=1 is ignored. The count is 8-bit with no wrap; len 255 gives 255 data bytes.
- reset_i mid-transaction returns to reset values on the next edge, regardless of byte-controller state.

Test Plan:
- Write addr 7'h50, len 2, TX 8'hA5, 8'h3C, all ACKs → commands START, WRITE 8'hA0, WRITE 8'hA5, WRITE 8'h3C, STOP; one done_o; nack_o=0.
- Read addr 7'h51, len 3, model returns 8'h11, 8'h22, 8'h33 → WRITE 8'hA3, three READs with master_ack_o 0,0,1; three rx_valid_o strobes with data in order; STOP; done_o.
- Write addr 7'h20, len 1, address NACK (byte_ack_i=1) → no data WRITE, STOP issued, done_o with nack_o=1, tx_ready_o never asserted.
- byte_al_i pulsed during second data WRITE of len 3 write → byte_cmd_o=NOP same cycle, no STOP, done_o next cycle with al_o=1, busy_o falls.
- Write len 4, tx_valid_i held low 50 cycles after first byte, abort_i asserted → STOP issued immediately, done_o, nack_o=0, al_o=0.
- len 0 probe to 7'h7F with ACK → START, WRITE 8'hFE, STOP, done_o; start_i pulses while busy produce no extra transaction.
